// File: rtl/uart_arb_pkg.sv
// Shared state encoding and default timing constants for the UART transmit arbiter.
// DELAY_FRAMES is one bit time at 27 MHz / 115200 baud and is shared with the UART itself.
package uart_arb_pkg;

  localparam int DELAY_FRAMES      = 234;
  localparam int DEF_GAP_CYCLES    = DELAY_FRAMES;
  localparam int DEF_STALL_TIMEOUT = 27000;
  localparam int DEF_MAX_PKT       = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STREAM = 2'd1,
    ARB_GAP    = 2'd2
  } arb_state_e;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Rotate-priority encoder: first asserted request scanning upward from rr_ptr_i, wrapping at N_REQ.
// Purely combinational, no backpressure.
module uart_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   rr_ptr_i,
  output logic             any_req_o,
  output logic [IDW-1:0]   winner_o
);

  int idx;

  // Scan from the farthest offset down so the nearest-to-pointer request is written last.
  always_comb begin
    any_req_o = 1'b0;
    winner_o  = '0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_i) + k) % N_REQ;
      if (req_i[idx]) begin
        any_req_o = 1'b1;
        winner_o  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter onto one UART byte interface; 1-cycle arbitration, then combinational passthrough
// with tx_ready gating req_ready and a forced idle gap per packet. Stall release via UART_TX_ARB_STALL_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = 3,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int MAX_PKT       = DEF_MAX_PKT,
  parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
  localparam int IDW          = $clog2((N_REQ > 2) ? N_REQ : 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 busy_o,
  output logic                 timeout_flag_o
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int GW = cnt_width(GAP_CYCLES);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

  logic            any_req;
  logic [IDW-1:0]  winner;
  logic            sel_valid, sel_last;
  logic [7:0]      sel_data;
  logic            xfer, release_pkt, stall_rel;
  logic [IDW-1:0]  next_ptr;

  uart_rr_picker #(.N_REQ(N_REQ), .IDW(IDW)) u_picker (
    .req_i     (req_valid_i),
    .rr_ptr_i  (rr_q),
    .any_req_o (any_req),
    .winner_o  (winner)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_valid = req_valid_i[i];
        sel_last  = req_last_i[i];
        sel_data  = req_data_i[i*8 +: 8];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (state_q == ARB_STREAM && grant_q == IDW'(i)) req_ready_o[i] = tx_ready_i;
    end
  end

  assign next_ptr   = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);
  assign grant_id_o = grant_q;

`ifdef UART_TX_ARB_STALL_TIMEOUT_EN
  localparam int SW = cnt_width(STALL_TIMEOUT);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  assign stall_rel = (state_q == ARB_STREAM) && !sel_valid && (stall_cnt_q == SW'(STALL_TIMEOUT - 1));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != ARB_STREAM || state_d != state_q || xfer) stall_cnt_d = '0;
    else if (!sel_valid) stall_cnt_d = stall_cnt_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign timeout_flag_o = stall_rel;
`else
  assign stall_rel      = 1'b0;
  assign timeout_flag_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    busy_o      = 1'b0;
    xfer        = 1'b0;
    release_pkt = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        busy_o     = 1'b1;
        tx_valid_o = sel_valid;
        tx_data_o  = sel_data;
        xfer       = sel_valid && tx_ready_i;
        if (xfer) begin
          if (sel_last || byte_cnt_q == CW'(MAX_PKT - 1)) release_pkt = 1'b1;
          else byte_cnt_d = byte_cnt_q + CW'(1);
        end
        if (stall_rel) release_pkt = 1'b1;
        if (release_pkt) begin
          rr_d       = next_ptr;
          byte_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
        end
      end
      ARB_GAP: begin
        busy_o = 1'b1;
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = ARB_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter with a queue-based rotation model and a scoreboard monitor.
module tb_uart_tx_arbiter;

  localparam int N    = 3;
  localparam int GAP  = 234;
  localparam int MAXP = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_flag;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .MAX_PKT(MAXP), .STALL_TIMEOUT(100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .grant_id_o     (grant_id),
    .busy_o         (busy),
    .timeout_flag_o (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [7:0] dat;
    bit         endseg;
  } exp_t;

  typedef logic [8:0] byteq_t [$];

  exp_t   sb_q [$];
  byteq_t drv_q [N];
  byteq_t mdl_q [N];
  logic [N-1:0] hold_low = '0;
  int     tx_mode = 0;
  int     m_rr = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     xfer_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester and transmitter driver: pops bytes accepted on the previous edge, then re-presents.
  initial begin : driver
    logic [N-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        req_valid[i]       = (drv_q[i].size() > 0) && !hold_low[i];
        req_data[i*8 +: 8] = (drv_q[i].size() > 0) ? drv_q[i][0][7:0] : 8'h00;
        req_last[i]        = (drv_q[i].size() > 0) ? drv_q[i][0][8] : 1'b0;
      end
      case (tx_mode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks per-cycle invariants.
  initial begin : monitor
    exp_t e;
    int   since;
    bit   armed;
    since = 0;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 1'b0;
      end else begin
        since++;
        if (!tx_ready) check("ready_while_tx_stalled", 32'(req_ready), 0);
        if (req_ready != '0) check("ready_onehot_grant", 32'(req_ready), 32'(1) << grant_id);
`ifndef UART_TX_ARB_STALL_TIMEOUT_EN
        if (busy) check("timeout_flag_zero", 32'(timeout_flag), 0);
`endif
        if (tx_valid && tx_ready) begin
          xfer_total++;
          check("xfer_expected", 32'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("xfer_src", 32'(grant_id), 32'(e.src));
            check("xfer_data", 32'(tx_data), 32'(e.dat));
            if (armed) check("gap_spacing", 32'(since >= GAP + 2), 1);
            armed = e.endseg;
            since = 0;
          end
        end
      end
    end
  end

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    drv_q[r].push_back({last, d});
    mdl_q[r].push_back({last, d});
  endtask

  task automatic push_pkt(input int r, input int len, input bit with_last);
    for (int b = 0; b < len; b++)
      push_byte(r, 8'($urandom_range(0, 255)), with_last && (b == len - 1));
  endtask

  // Rotation model: next server is the first requester with pending bytes after the last one served;
  // each grant covers bytes up to and including last, capped at MAXP.
  task automatic model_run();
    int w, idx, n;
    bit done;
    logic [8:0] b;
    exp_t e;
    forever begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && mdl_q[idx].size() > 0) w = idx;
      end
      if (w < 0) break;
      n = 0;
      done = 1'b0;
      while (!done && mdl_q[w].size() > 0) begin
        b = mdl_q[w].pop_front();
        n++;
        e.src = w;
        e.dat = b[7:0];
        e.endseg = b[8] || (n == MAXP);
        sb_q.push_back(e);
        done = e.endseg;
      end
      if (!done) break;
      m_rr = (w + 1) % N;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() > 0 && t < 6000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("drain_in_time", 32'(sb_q.size()), 0);
    sb_q.delete();
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("idle_in_time", 32'(busy), 0);
  endtask

  task automatic wait_xfer(input int target);
    int t = 0;
    while (xfer_total < target && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("xfer_reached", 32'(xfer_total >= target), 1);
  endtask

  task automatic flush_all();
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    m_rr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_all();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : main
    int base, cnt, mask;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout_flag), 0);
    #1 rst_n = 1'b1;

    // Single packet and gap length.
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b1);
    model_run();
    wait_drain();
    cnt = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
      cnt++;
    end
    check("gap_busy_cycles", 32'(cnt), GAP);

    // Contention from rr=0, then from rr=1.
    do_reset();
    push_byte(0, 8'h10, 1'b1);
    push_byte(1, 8'h20, 1'b1);
    push_byte(2, 8'h30, 1'b1);
    model_run();
    wait_drain();
    wait_idle();
    push_byte(0, 8'h05, 1'b1);
    model_run();
    wait_drain();
    wait_idle();
    push_byte(0, 8'h10, 1'b1);
    push_byte(1, 8'h20, 1'b1);
    push_byte(2, 8'h30, 1'b1);
    model_run();
    wait_drain();
    wait_idle();

    // Backpressure: toggling tx_ready, exactly four transfers.
    tx_mode = 1;
    base = xfer_total;
    push_pkt(1, 4, 1'b1);
    model_run();
    wait_drain();
    wait_idle();
    check("bp_xfer_count", 32'(xfer_total - base), 4);
    tx_mode = 0;

    // MAX_PKT split: six bytes without last, regrant of the sole requester, then grant held.
    push_pkt(1, 6, 1'b0);
    model_run();
    wait_drain();
    repeat (20) @(negedge clk);
    #1;
    check("held_busy", 32'(busy), 1);
    check("held_grant", 32'(grant_id), 1);
    check("held_tx_valid", 32'(tx_valid), 0);
    do_reset();

    // Mid-packet valid drop: grant held, nobody else served.
    base = xfer_total;
    push_pkt(0, 3, 1'b1);
    push_pkt(1, 1, 1'b1);
    model_run();
    wait_xfer(base + 1);
    hold_low[0] = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("stall_no_xfer", 32'(xfer_total - base), 1);
    check("stall_grant", 32'(grant_id), 0);
    check("stall_tx_valid", 32'(tx_valid), 0);
    hold_low[0] = 1'b0;
    wait_drain();
    wait_idle();

    // Reset after byte 2 of 5 on requester 2.
    base = xfer_total;
    push_pkt(2, 5, 1'b1);
    model_run();
    wait_xfer(base + 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    flush_all();
    @(negedge clk);
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_grant", 32'(grant_id), 0);
    check("midrst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    push_byte(2, 8'h03, 1'b1);
    push_byte(1, 8'h02, 1'b1);
    push_byte(0, 8'h01, 1'b1);
    model_run();
    wait_drain();
    wait_idle();

    // Random rounds.
    for (int r = 0; r < 25; r++) begin
      tx_mode = $urandom_range(0, 2);
      mask = $urandom_range(1, 7);
      for (int i = 0; i < N; i++)
        if (mask[i]) push_pkt(i, $urandom_range(1, 7), 1'b1);
      model_run();
      wait_drain();
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
